// File: rtl/nnrv_pkg.sv
// Shared types and constants for the nnrv memory arbiter.
package nnrv_pkg;

    localparam logic TAG_IF = 1'b0;
    localparam logic TAG_D  = 1'b1;

    typedef enum logic {
        PRI_D  = 1'b0,
        PRI_IF = 1'b1
    } arb_state_e;

endpackage

// File: rtl/nnrv_rsp_pipe.sv
// Read-response delay line: carries {valid, tag} for RD_LAT cycles to line up with RAM read data.
module nnrv_rsp_pipe #(
    parameter int unsigned RD_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    input  logic in_tag,
    output logic out_valid,
    output logic out_tag
);

    logic [RD_LAT-1:0] valid_q;
    logic [RD_LAT-1:0] tag_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            tag_q   <= '0;
        end else begin
            valid_q[0] <= in_valid;
            tag_q[0]   <= in_tag;
            for (int i = 1; i < RD_LAT; i++) begin
                valid_q[i] <= valid_q[i-1];
                tag_q[i]   <= tag_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[RD_LAT-1];
    assign out_tag   = tag_q[RD_LAT-1];

endmodule

// File: rtl/nnrv_mem_arb.sv
// Single-port RAM arbiter between fetch (read-only) and data (read/write) requesters,
// data-priority with a bounded-starvation guarantee for fetch.
module nnrv_mem_arb
    import nnrv_pkg::*;
#(
    parameter int unsigned XLEN         = 64,
    parameter int unsigned ADDR_WIDTH   = 10,
    parameter int unsigned MASK_WIDTH   = 8,
    parameter int unsigned RD_LAT       = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_if_req,
    input  logic [XLEN-1:0]       i_if_addr,
    output logic                  o_if_gnt,
    output logic                  o_if_rvalid,
    output logic [XLEN-1:0]       o_if_rdata,
    input  logic                  i_d_req,
    input  logic                  i_d_we,
    input  logic [XLEN-1:0]       i_d_addr,
    input  logic [XLEN-1:0]       i_d_wdata,
    input  logic [MASK_WIDTH-1:0] i_d_mask,
    output logic                  o_d_gnt,
    output logic                  o_d_rvalid,
    output logic [XLEN-1:0]       o_d_rdata,
    output logic                  o_ram_en,
    output logic                  o_ram_we,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    output logic [MASK_WIDTH-1:0] o_ram_mask,
    output logic [XLEN-1:0]       o_ram_wdata,
    input  logic [XLEN-1:0]       i_ram_rdata
);

    localparam logic [MASK_WIDTH-1:0] MASK_ALL = {MASK_WIDTH{1'b1}};
    localparam logic [3:0]            LIMIT_M1 = 4'(STARVE_LIMIT - 1);

    arb_state_e state_q;
    logic [3:0] cnt_q;
    logic       if_gnt;
    logic       d_gnt;
    logic       rsp_valid;
    logic       rsp_tag;
    logic       unused_addr;

    // Grants are forced low during reset so every output reads zero.
    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (i_rst_n) begin
            if (state_q == PRI_IF) begin
                if (i_if_req) if_gnt = 1'b1;
                else if (i_d_req) d_gnt = 1'b1;
            end else begin
                if (i_d_req) d_gnt = 1'b1;
                else if (i_if_req) if_gnt = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= PRI_D;
            cnt_q   <= '0;
        end else begin
            if (!i_if_req || if_gnt) cnt_q <= '0;
            else if (d_gnt) cnt_q <= cnt_q + 4'd1;

            if (if_gnt) begin
                state_q <= PRI_D;
            end else if (state_q == PRI_D && d_gnt && i_if_req && cnt_q == LIMIT_M1) begin
                state_q <= PRI_IF;
            end
        end
    end

    always_comb begin
        o_ram_en    = if_gnt | d_gnt;
        o_ram_we    = d_gnt & i_d_we;
        o_ram_addr  = '0;
        o_ram_mask  = '0;
        o_ram_wdata = '0;
        if (if_gnt) begin
            o_ram_addr = i_if_addr[ADDR_WIDTH-1:0];
            o_ram_mask = MASK_ALL;
        end else if (d_gnt) begin
            o_ram_addr  = i_d_addr[ADDR_WIDTH-1:0];
            o_ram_mask  = i_d_mask;
            o_ram_wdata = i_d_wdata;
        end
    end

    assign unused_addr = ^{i_if_addr[XLEN-1:ADDR_WIDTH], i_d_addr[XLEN-1:ADDR_WIDTH]};

    nnrv_rsp_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rsp_pipe (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .in_valid  (o_ram_en & ~o_ram_we),
        .in_tag    (d_gnt ? TAG_D : TAG_IF),
        .out_valid (rsp_valid),
        .out_tag   (rsp_tag)
    );

    assign o_if_gnt    = if_gnt;
    assign o_d_gnt     = d_gnt;
    assign o_if_rvalid = rsp_valid & (rsp_tag == TAG_IF);
    assign o_d_rvalid  = rsp_valid & (rsp_tag == TAG_D);
    assign o_if_rdata  = o_if_rvalid ? i_ram_rdata : '0;
    assign o_d_rdata   = o_d_rvalid ? i_ram_rdata : '0;

endmodule

// File: tb/tb_nnrv_mem_arb.sv
// Directed, table-driven bench for nnrv_mem_arb (RD_LAT=1, STARVE_LIMIT=4) with a byte-masked RAM.
module tb_nnrv_mem_arb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [63:0] if_addr = '0;
    logic        if_gnt, if_rvalid;
    logic [63:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [63:0] d_addr = '0;
    logic [63:0] d_wdata = '0;
    logic [7:0]  d_mask = '0;
    logic        d_gnt, d_rvalid;
    logic [63:0] d_rdata;
    logic        ram_en, ram_we;
    logic [9:0]  ram_addr;
    logic [7:0]  ram_mask;
    logic [63:0] ram_wdata;
    logic [63:0] ram_rdata = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nnrv_mem_arb #(
        .XLEN         (64),
        .ADDR_WIDTH   (10),
        .MASK_WIDTH   (8),
        .RD_LAT       (1),
        .STARVE_LIMIT (4)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_if_req    (if_req),
        .i_if_addr   (if_addr),
        .o_if_gnt    (if_gnt),
        .o_if_rvalid (if_rvalid),
        .o_if_rdata  (if_rdata),
        .i_d_req     (d_req),
        .i_d_we      (d_we),
        .i_d_addr    (d_addr),
        .i_d_wdata   (d_wdata),
        .i_d_mask    (d_mask),
        .o_d_gnt     (d_gnt),
        .o_d_rvalid  (d_rvalid),
        .o_d_rdata   (d_rdata),
        .o_ram_en    (ram_en),
        .o_ram_we    (ram_we),
        .o_ram_addr  (ram_addr),
        .o_ram_mask  (ram_mask),
        .o_ram_wdata (ram_wdata),
        .i_ram_rdata (ram_rdata)
    );

    function automatic logic [63:0] winit(int i);
        logic [15:0] lo;
        lo = i[15:0];
        return {16'hC0DE, lo, 16'hBEEF, lo};
    endfunction

    // 1-cycle-latency RAM; a write lands before a read issued in the next cycle.
    logic [63:0] mem [1024];
    logic        loaded = 1'b0;
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 1024; i++) mem[i] <= winit(i);
            loaded <= 1'b1;
        end else if (ram_en) begin
            if (ram_we) begin
                for (int b = 0; b < 8; b++)
                    if (ram_mask[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
            end else begin
                ram_rdata <= mem[ram_addr];
            end
        end
    end

    typedef struct {
        logic        if_req;
        logic [63:0] if_addr;
        logic        d_req;
        logic        d_we;
        logic [63:0] d_addr;
        logic [63:0] d_wdata;
        logic [7:0]  d_mask;
        logic        e_if_gnt;
        logic        e_d_gnt;
        logic        e_if_rv;
        logic        e_d_rv;
        logic [63:0] e_rdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic ir, logic [63:0] ia, logic dr, logic dw, logic [63:0] da,
                                logic [63:0] wd, logic [7:0] m, logic gi, logic gd,
                                logic ri, logic rd, logic [63:0] rdat);
        vec_t v;
        v.if_req = ir; v.if_addr = ia; v.d_req = dr; v.d_we = dw; v.d_addr = da;
        v.d_wdata = wd; v.d_mask = m; v.e_if_gnt = gi; v.e_d_gnt = gd;
        v.e_if_rv = ri; v.e_d_rv = rd; v.e_rdata = rdat;
        return v;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(vec_t v, int idx);
        logic [63:0] ea;
        @(negedge clk);
        if_req = v.if_req; if_addr = v.if_addr;
        d_req = v.d_req; d_we = v.d_we; d_addr = v.d_addr;
        d_wdata = v.d_wdata; d_mask = v.d_mask;
        #2;
        chk($sformatf("v%0d if_gnt", idx), 64'(if_gnt), 64'(v.e_if_gnt));
        chk($sformatf("v%0d d_gnt", idx), 64'(d_gnt), 64'(v.e_d_gnt));
        chk($sformatf("v%0d ram_en", idx), 64'(ram_en), 64'(v.e_if_gnt | v.e_d_gnt));
        chk($sformatf("v%0d if_rvalid", idx), 64'(if_rvalid), 64'(v.e_if_rv));
        chk($sformatf("v%0d d_rvalid", idx), 64'(d_rvalid), 64'(v.e_d_rv));
        chk($sformatf("v%0d if_rdata", idx), if_rdata, v.e_if_rv ? v.e_rdata : 64'h0);
        chk($sformatf("v%0d d_rdata", idx), d_rdata, v.e_d_rv ? v.e_rdata : 64'h0);
        if (v.e_if_gnt || v.e_d_gnt) begin
            ea = v.e_if_gnt ? v.if_addr : v.d_addr;
            chk($sformatf("v%0d ram_we", idx), 64'(ram_we), 64'(v.e_d_gnt & v.d_we));
            chk($sformatf("v%0d ram_addr", idx), 64'(ram_addr), 64'(ea[9:0]));
            chk($sformatf("v%0d ram_mask", idx), 64'(ram_mask),
                64'(v.e_if_gnt ? 8'hFF : v.d_mask));
        end
    endtask

    task automatic chk_all_zero(string name);
        chk({name, " gnts"}, {62'h0, if_gnt, d_gnt}, 64'h0);
        chk({name, " rvalids"}, {62'h0, if_rvalid, d_rvalid}, 64'h0);
        chk({name, " rdata"}, if_rdata | d_rdata, 64'h0);
        chk({name, " ram_ctl"}, {44'h0, ram_en, ram_we, ram_addr, ram_mask}, 64'h0);
        chk({name, " ram_wdata"}, ram_wdata, 64'h0);
    endtask

    initial begin
        string       pat;
        logic [63:0] t8, tc, t20, t40, t10w;
        logic        pg;
        t8   = winit(8);
        tc   = winit(12);
        t20  = winit(32);
        t40  = winit(64);
        t10w = {winit(16) >> 32, 32'hDEAD_BEEF};

        // Both requests held for 12 cycles: D,D,D,D,IF repeating.
        pat = "DDDDIDDDDIDD";
        for (int k = 0; k < 12; k++) begin
            logic gi;
            gi = (pat[k] == "I");
            pg = (k > 0) && (pat[k-1] == "I");
            vecs.push_back(mk(1, 64'h8, 1, 0, 64'h20, 0, 8'hFF, gi, !gi,
                              k > 0 && pg, k > 0 && !pg, pg ? t8 : t20));
        end
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, t20));
        // Fetch-only stream at 0x40.
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(1, 64'h40, 0, 0, 0, 0, 0, 1, 0, k > 0, 0, t40));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, t40));
        // Partial write then read-back of 0x10.
        vecs.push_back(mk(0, 0, 1, 1, 64'h10, 64'hDEAD_BEEF, 8'h0F, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 64'h10, 0, 8'hFF, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, t10w));
        // Interleaved reads, responses in grant order.
        vecs.push_back(mk(1, 64'h8, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 64'h20, 0, 8'hFF, 0, 1, 1, 0, t8));
        vecs.push_back(mk(1, 64'hC, 0, 0, 0, 0, 0, 1, 0, 0, 1, t20));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, tc));
        // High address bits wrap onto 0x20.
        vecs.push_back(mk(0, 0, 1, 0, 64'hFFFF_0000_0000_0420, 0, 8'h3C, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, t20));

        // Reset held with both requests asserted.
        if_req = 1'b1; d_req = 1'b1; if_addr = 64'h8; d_addr = 64'h20; d_mask = 8'hFF;
        repeat (3) @(posedge clk);
        @(negedge clk); #2;
        chk_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        foreach (vecs[i]) apply(vecs[i], i);

        // Raise the starve counter to 3 with a read in flight, then reset.
        apply(mk(1, 64'h8, 1, 0, 64'h20, 0, 8'hFF, 0, 1, 0, 0, 0), 100);
        apply(mk(1, 64'h8, 1, 0, 64'h20, 0, 8'hFF, 0, 1, 0, 1, t20), 101);
        apply(mk(1, 64'h8, 1, 0, 64'h20, 0, 8'hFF, 0, 1, 0, 1, t20), 102);
        @(negedge clk);
        rst_n = 1'b0; if_req = 1'b0; d_req = 1'b0;
        #2;
        chk_all_zero("midflight_reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 200);
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 201);
        // Counter must restart from 0: four data grants before fetch wins.
        for (int k = 0; k < 5; k++)
            apply(mk(1, 64'h8, 1, 0, 64'h20, 0, 8'hFF, k == 4, k != 4, 0, k > 0, t20), 202 + k);
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, t8), 207);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
